// File: rtl/pattern_resp_pkg.sv
// Shared types and constants for the pattern response checker: FSM states,
// default MISR polynomial/seed and the bit positions of the upstream responses.
package pattern_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [15:0] MISR_POLY_DEFAULT = 16'hB400;
    localparam logic [15:0] MISR_SEED_DEFAULT = 16'h0000;

    // Bit positions of the merged-pattern stage outputs on resp_in
    localparam int unsigned RESP_G42_1    = 0;
    localparam int unsigned RESP_N_572_1  = 1;
    localparam int unsigned RESP_N_573_1  = 2;
    localparam int unsigned RESP_N_549_1  = 3;
    localparam int unsigned RESP_N_569_1  = 4;
    localparam int unsigned RESP_N_452_1  = 5;
    localparam int unsigned RESP_G199_4   = 6;
    localparam int unsigned RESP_G214_4   = 7;
    localparam int unsigned RESP_ACVQN1_5 = 8;
    localparam int unsigned RESP_P6_5     = 9;
    localparam int unsigned RESP_COUNT    = 10;

endpackage

// File: rtl/misr_core.sv
// Galois-style multiple-input signature register: shift with feedback, XOR in a
// data word on each enabled cycle; load overrides with a seed value.
module misr_core
    import pattern_resp_pkg::*;
#(
    parameter int unsigned        SIG_W = 16,
    parameter logic [SIG_W-1:0]   POLY  = SIG_W'(MISR_POLY_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/pattern_resp_misr.sv
// Response checker: discards a warm-up window, compacts a capture window into a
// MISR and compares the final signature against a golden value latched on start.
module pattern_resp_misr
    import pattern_resp_pkg::*;
#(
    parameter int unsigned      IN_W    = RESP_COUNT,
    parameter int unsigned      SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(MISR_POLY_DEFAULT),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(MISR_SEED_DEFAULT),
    parameter int unsigned      WARMUP  = 2,
    parameter int unsigned      CAP_LEN = 64
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic [SIG_W-1:0] golden,
    input  logic             resp_valid,
    input  logic [IN_W-1:0]  resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      cap_count
);

    localparam int unsigned        CNT_W     = 16;
    localparam int unsigned        WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WARM_W-1:0]  WARM_LAST = WARM_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [CNT_W-1:0]   CAP_LAST  = CNT_W'((CAP_LEN > 0) ? (CAP_LEN - 1) : 0);

    if (IN_W > SIG_W) begin : g_bad_width
        $error("pattern_resp_misr: IN_W must not exceed SIG_W");
    end
    if (CAP_LEN == 0) begin : g_bad_caplen
        $error("pattern_resp_misr: CAP_LEN must be at least 1");
    end

    state_t              state;
    logic [WARM_W-1:0]   warm_cnt;
    logic [CNT_W-1:0]    cap_cnt;
    logic [SIG_W-1:0]    golden_q;
    logic [SIG_W-1:0]    sig;
    logic                start_ok;
    logic                misr_en;
    logic [SIG_W-1:0]    misr_din;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign misr_en  = (state == CAPTURE) && resp_valid;
    assign misr_din = SIG_W'(resp_in);

    misr_core #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk  (blif_clk_net),
        .rst  (blif_reset_net),
        .load (start_ok),
        .seed (SEED),
        .en   (misr_en),
        .din  (misr_din),
        .sig  (sig)
    );

    // Sequencer: a start is only accepted from IDLE or DONE and always wins there.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            warm_cnt <= '0;
            cap_cnt  <= '0;
            golden_q <= '0;
        end else if (start_ok) begin
            golden_q <= golden;
            warm_cnt <= '0;
            cap_cnt  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            state    <= (WARMUP > 0) ? FLUSH : CAPTURE;
        end else begin
            case (state)
                FLUSH: begin
                    if (resp_valid) begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                        if (warm_cnt == WARM_LAST) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (resp_valid) begin
                        if (cap_cnt != '1) begin
                            cap_cnt <= cap_cnt + CNT_W'(1);
                        end
                        if (cap_cnt == CAP_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                // Signature is final by now, so done and pass rise together.
                DONE: begin
                    done <= 1'b1;
                    pass <= (sig == golden_q);
                end
                default: begin
                end
            endcase
        end
    end

    assign signature = sig;
    assign cap_count = cap_cnt;

endmodule
